// File: rtl/kbd_pkg.sv
// Shared constants, FSM encoding and event layout for the keyboard event controller.
package kbd_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_LOOKUP,
    ST_PUSH
  } state_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] scan;
    logic [7:0] ascii;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

  function automatic logic is_shift(input logic [7:0] sc);
    return (sc == SC_LSHIFT) || (sc == SC_RSHIFT);
  endfunction

endpackage

// File: rtl/kbd_evt_fifo.sv
// First-word fall-through event queue; the head word reads as zero while empty.
module kbd_evt_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             i_push,
  input  logic [EVT_W-1:0] i_wdata,
  input  logic             i_pop,
  output logic [EVT_W-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [EVT_W-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = w_empty;
  assign o_full  = w_full;

endmodule

// File: rtl/kbd_event_ctrl.sv
// PS/2 scancode decoder: tracks shift/caps state, looks up ASCII externally and queues key events.
module kbd_event_ctrl
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter bit REPEAT_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] ps2_data,
  input  logic       ps2_valid,
  output logic [7:0] lut_addr,
  output logic       lut_caps,
  input  logic [7:0] lut_data,
  output logic       evt_valid,
  output logic [7:0] evt_scan,
  output logic [7:0] evt_ascii,
  output logic       evt_ext,
  input  logic       evt_rd,
  output logic       caps_on,
  output logic       shift_on,
  output logic       ovf,
  input  logic       ovf_clr
);

  state_t     r_state, w_next_state;
  logic [7:0] r_lut_addr, w_lut_addr;
  logic       r_caps, w_caps;
  logic       r_shift, w_shift;
  logic [7:0] r_held, w_held;
  evt_t       r_evt, w_evt;
  logic       r_ovf;

  logic w_byte_drop;
  logic w_push;
  logic w_full_drop;
  logic w_empty;
  logic w_full;
  evt_t w_head;

  // A make equal to the held key is a typematic repeat.
  logic w_accept_make;
  assign w_accept_make = REPEAT_EN || (ps2_data != r_held);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    w_next_state = r_state;
    w_lut_addr   = r_lut_addr;
    w_caps       = r_caps;
    w_shift      = r_shift;
    w_held       = r_held;
    w_evt        = r_evt;
    w_byte_drop  = 1'b0;
    w_push       = 1'b0;
    unique case (r_state)
      ST_IDLE: if (ps2_valid) begin
        if (ps2_data == SC_EXT) begin
          w_next_state = ST_EXT;
        end else if (ps2_data == SC_BRK) begin
          w_next_state = ST_BRK;
        end else if (is_shift(ps2_data)) begin
          w_shift = 1'b1;
          w_held  = ps2_data;
        end else if (ps2_data == SC_CAPS) begin
          if (r_held != SC_CAPS) w_caps = !r_caps;
          w_held = ps2_data;
        end else if (w_accept_make) begin
          w_held       = ps2_data;
          w_lut_addr   = ps2_data;
          w_next_state = ST_LOOKUP;
        end
      end
      ST_EXT: if (ps2_valid) begin
        if (ps2_data == SC_BRK) begin
          w_next_state = ST_EXTBRK;
        end else if (w_accept_make) begin
          w_held       = ps2_data;
          w_evt.ext    = 1'b1;
          w_evt.scan   = ps2_data;
          w_evt.ascii  = 8'h00;
          w_next_state = ST_PUSH;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_BRK: if (ps2_valid) begin
        if (is_shift(ps2_data)) w_shift = 1'b0;
        if (ps2_data == r_held) w_held = 8'h00;
        w_next_state = ST_IDLE;
      end
      ST_EXTBRK: if (ps2_valid) begin
        if (ps2_data == r_held) w_held = 8'h00;
        w_next_state = ST_IDLE;
      end
      ST_LOOKUP: begin
        w_evt.ext    = 1'b0;
        w_evt.scan   = r_lut_addr;
        w_evt.ascii  = lut_data;
        w_byte_drop  = ps2_valid;
        w_next_state = ST_PUSH;
      end
      ST_PUSH: begin
        w_push       = 1'b1;
        w_byte_drop  = ps2_valid;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // A full queue still accepts the push when the head is popped in the same cycle.
  assign w_full_drop = w_push && w_full && !evt_rd;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state    <= ST_IDLE;
      r_lut_addr <= 8'h00;
      r_caps     <= 1'b0;
      r_shift    <= 1'b0;
      r_held     <= 8'h00;
      r_evt      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_lut_addr <= w_lut_addr;
      r_caps     <= w_caps;
      r_shift    <= w_shift;
      r_held     <= w_held;
      r_evt      <= w_evt;
      if (w_byte_drop || w_full_drop) r_ovf <= 1'b1;
      else if (ovf_clr)               r_ovf <= 1'b0;
    end
  end

  kbd_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .i_push  (w_push),
    .i_wdata (r_evt),
    .i_pop   (evt_rd),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign lut_addr  = r_lut_addr;
  assign lut_caps  = r_caps ^ r_shift;
  assign evt_valid = !w_empty;
  assign evt_scan  = w_head.scan;
  assign evt_ascii = w_head.ascii;
  assign evt_ext   = w_head.ext;
  assign caps_on   = r_caps;
  assign shift_on  = r_shift;
  assign ovf       = r_ovf;

endmodule

// File: doc/kbd_event_ctrl.md
KBD_EVENT_CTRL -- requirements
Module: kbd_event_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, key-event queue depth (power of two, 2..64).
REQ-002 Parameter REPEAT_EN, default 1, 1 = typematic repeat makes are queued, 0 = repeats are suppressed.
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 clrn  in  1  asynchronous active-low reset.
REQ-005 ps2_data  in  8  received scancode byte from PS/2 receiver.
REQ-006 ps2_valid  in  1  one-cycle strobe, ps2_data valid.
REQ-007 lut_addr  out  8  scancode address to the external scancode->ASCII lookup.
REQ-008 lut_caps  out  1  case-select to the lookup, equal to caps_on XOR shift_on.
REQ-009 lut_data  in  8  combinational ASCII from the lookup, sampled one cycle after lut_addr is driven.
REQ-010 evt_valid  out  1  queue non-empty.
REQ-011 evt_scan  out  8  head event scancode, first-word fall-through.
REQ-012 evt_ascii  out  8  head event ASCII; 0x00 for extended keys.
REQ-013 evt_ext  out  1  head event was E0-prefixed.
REQ-014 evt_rd  in  1  pop head; ignored when evt_valid=0.
REQ-015 caps_on, shift_on  out  1 each  current lock and shift state.
REQ-016 ovf  out  1  sticky flag: an event or byte was dropped.
REQ-017 ovf_clr  in  1  clears ovf; a set event in the same cycle wins.

Function
REQ-018 Decode FSM states: IDLE, EXT (after E0), BRK (after F0), EXTBRK (after E0 F0), LOOKUP, PUSH.
REQ-019 IDLE: E0->EXT, F0->BRK, any other byte->make handling; EXT: F0->EXTBRK, other byte->extended make; BRK and EXTBRK: next byte is a break and returns the FSM to IDLE.
REQ-020 Non-extended make 0x12 or 0x59 sets shift_on and is not queued; a break of the same code clears shift_on.
REQ-021 Non-extended make 0x58 toggles caps_on only if 0x58 is not already held, and is not queued.
REQ-022 Any other non-extended make latches the scancode into lut_addr and enters LOOKUP; the next cycle registers lut_data into the event and enters PUSH.
REQ-023 Extended make skips LOOKUP and goes directly to PUSH with ascii=0x00 and ext=1.
REQ-024 PUSH writes {ext, scan, ascii} into the queue in one cycle, then returns to IDLE; ps2_valid-to-evt_valid latency is 3 cycles non-extended and 2 cycles extended, with the queue empty.
REQ-025 held register: set to the scancode on a make and cleared on the matching break; when REPEAT_EN=0, a make equal to held is discarded.
REQ-026 Breaks are never queued.
REQ-027 ps2_valid arriving in LOOKUP or PUSH drops the byte and sets ovf.
REQ-028 PUSH with the queue full drops the event and sets ovf; if evt_rd is asserted in the same cycle, both the pop and the push succeed.
REQ-029 Pop and push on an empty queue: the push is accepted and the pop is ignored.
REQ-030 Read and write pointers are $clog2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full and empty are distinguished by the MSB.
REQ-031 lut_caps is combinational from the registered caps_on and shift_on.

Reset
REQ-032 clrn low, asynchronously: FSM=IDLE, queue empty, evt_valid=0, evt_scan/evt_ascii=0x00, evt_ext=0, lut_addr=0x00, caps_on=0, shift_on=0, held=0x00, ovf=0.
REQ-033 Reset mid-sequence (for example after F0) discards the partial sequence; the first post-reset byte is decoded from IDLE.

Structure
REQ-034 Package kbd_pkg holds SC_EXT=0xE0, SC_BRK=0xF0, SC_CAPS=0x58, SC_LSHIFT=0x12, SC_RSHIFT=0x59, the FSM state encoding, and the 17-bit event width.
REQ-035 Queue is sub-module kbd_evt_fifo (synchronous FWFT, same clk/clrn); the lookup stays external.

Verification
REQ-036 Send 1C, then F0 1C, with a bench LUT mapping 1C->0x61 -> one event {scan=1C, ascii=61, ext=0} after 3 cycles; break not queued.
REQ-037 Send 58, F0 58, 1C -> caps_on=1, event ascii=0x41; send 12, 1C -> lut_caps=0, ascii=0x61.
REQ-038 Send E0 75, then E0 F0 75 -> one event {scan=75, ascii=00, ext=1}; FSM back in IDLE.
REQ-039 Send 9 makes with evt_rd=0, FIFO_DEPTH=8 -> 8 events queued, ovf=1, ninth dropped; then evt_rd held during a push with the queue full -> count stays 8 with correct order.
REQ-040 REPEAT_EN=0: send 1C 1C 1C -> one event; then F0 1C, 1C -> second event.
REQ-041 Pulse clrn low after F0 -> all outputs at reset values; then 1C -> a make event, not treated as a break.
